// File: rtl/bcd_pkg.sv
// bcd_pkg: shared BCD constants and conversion/validity helpers
package bcd_pkg;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;
  function automatic logic [63:0] int_to_bcd(input int value, input int digits);
    logic [63:0] r;
    int v;
    r = '0;
    v = value;
    for (int i = 0; i < digits; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  function automatic logic bcd_valid(input logic [63:0] vec, input int digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < digits; i++)
      if (vec[4*i+:4] > BCD_MAX) ok = 1'b0;
    return ok;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit register with load, forced wrap value and up/down step
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] rst_val,
  input  logic       step,
  input  logic       up_dn,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       frc,
  input  logic [3:0] frc_val,
  output logic [3:0] digit,
  output logic       at_hi,
  output logic       at_lo
);
  assign at_hi = digit == BCD_MAX;
  assign at_lo = digit == BCD_MIN;
  // reset > load > range wrap > step; stepping rolls 9->0 up and 0->9 down
  always_ff @(posedge clk)
    if (rst) digit <= rst_val;
    else if (ld) digit <= ld_val;
    else if (frc) digit <= frc_val;
    else if (step) digit <= up_dn ? (at_hi ? BCD_MIN : digit + 4'd1) : (at_lo ? BCD_MAX : digit - 4'd1);
endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: multi-digit BCD up/down modulo counter with checked load and cascadable tc
module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MODULUS = 12,
  parameter int MIN_VAL = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] cnt_bcd,
  output logic                tc,
  output logic                load_err
);
  localparam int W = 4 * DIGITS;
  localparam int MAX_VAL = MIN_VAL + MODULUS - 1;
  localparam logic [63:0] MIN_FULL = int_to_bcd(MIN_VAL, DIGITS);
  localparam logic [63:0] MAX_FULL = int_to_bcd(MAX_VAL, DIGITS);
  localparam logic [W-1:0] MIN_BCD = MIN_FULL[W-1:0];
  localparam logic [W-1:0] MAX_BCD = MAX_FULL[W-1:0];
  if (MODULUS < 2 || MAX_VAL >= 10 ** DIGITS) begin : g_bad_params
    $error("bcd_mod_counter: range does not fit in DIGITS BCD digits");
  end
  logic legal, at_end, wrap, adv;
  logic [DIGITS:0] chain;
  logic [DIGITS-1:0] at_hi, at_lo;
  logic unused_carry;
  // valid BCD orders the same as binary, so range checks compare the raw vectors
  assign legal = bcd_valid(64'(load_val), DIGITS) && load_val >= MIN_BCD && load_val <= MAX_BCD;
  assign at_end = up_dn ? cnt_bcd == MAX_BCD : cnt_bcd == MIN_BCD;
  assign wrap = en & ~load & at_end;
  assign adv = en & ~load & ~at_end;
  assign tc = wrap;
  assign chain[0] = adv;
  assign unused_carry = chain[DIGITS];
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign chain[i+1] = chain[i] & (up_dn ? at_hi[i] : at_lo[i]);
    bcd_digit u_digit (
      .clk(clk),
      .rst(rst),
      .rst_val(MIN_BCD[4*i+:4]),
      .step(chain[i]),
      .up_dn(up_dn),
      .ld(load),
      .ld_val(legal ? load_val[4*i+:4] : MIN_BCD[4*i+:4]),
      .frc(wrap),
      .frc_val(up_dn ? MIN_BCD[4*i+:4] : MAX_BCD[4*i+:4]),
      .digit(cnt_bcd[4*i+:4]),
      .at_hi(at_hi[i]),
      .at_lo(at_lo[i])
    );
  end
  // one-cycle pulse for each rejected load
  always_ff @(posedge clk)
    load_err <= rst ? 1'b0 : load & ~legal;
endmodule
